// File: rtl/long_inst_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : long_inst_scoreboard_pkg
// Brief   : Shared types and constants for the long-latency instruction
//           scoreboard (ID type, entry record, default sizes).
// Revision: 1.0 - initial release
// ============================================================================
package long_inst_scoreboard_pkg;

  localparam int SB_ID_WIDTH       = 2;
  localparam int SB_NUM_ENTRIES    = 2 ** SB_ID_WIDTH;
  localparam int SB_REG_ADDR_WIDTH = 5;

  typedef logic [SB_ID_WIDTH-1:0] inst_id_t;

  // One tracked in-flight instruction: busy flag and pending destination.
  typedef struct packed {
    logic                         valid;
    logic [SB_REG_ADDR_WIDTH-1:0] rd;
  } sb_entry_t;

endpackage : long_inst_scoreboard_pkg
`default_nettype wire

// File: rtl/long_inst_scoreboard_sb_prio_enc.sv
`default_nettype none
// ============================================================================
// Module  : sb_prio_enc
// Brief   : Lowest-free-index priority encoder with an any-free flag.
//           A set bit in busy_i marks an occupied slot.
// Revision: 1.0 - initial release
// ============================================================================
module sb_prio_enc #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   busy_i,
  output logic [IDW-1:0] idx_o,
  output logic           any_free_o
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_i[i]) idx_o = IDW'(i);
    end
  end

  assign any_free_o = ~&busy_i;

endmodule : sb_prio_enc
`default_nettype wire

// File: rtl/long_inst_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : long_inst_scoreboard
// Brief   : Tracks in-flight long-latency instructions (loads, MUL/DIV)
//           from issue to writeback, hands out IDs and flags RAW/WAW
//           hazards for the instruction in decode.
//           Optional: define LONG_INST_SB_ERR_EN to add err_o/err_id_o,
//           reporting the first commit aimed at a non-valid entry.
// Revision: 1.0 - initial release
// ============================================================================
module long_inst_scoreboard
  import long_inst_scoreboard_pkg::*;
#(
  parameter int NUM_ENTRIES    = SB_NUM_ENTRIES,
  parameter int ID_WIDTH       = SB_ID_WIDTH,
  parameter int REG_ADDR_WIDTH = SB_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  // allocation from decode
  input  logic                      alloc_req_i,
  input  logic [REG_ADDR_WIDTH-1:0] alloc_rd_i,
  output logic                      alloc_ready_o,
  output logic [ID_WIDTH-1:0]       alloc_id_o,
  // hazard check for the decode instruction
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs1_i,
  input  logic                      dec_rs1_re_i,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs2_i,
  input  logic                      dec_rs2_re_i,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rd_i,
  input  logic                      dec_we_i,
  output logic                      raw_hazard_o,
  output logic                      waw_hazard_o,
  output logic                      stall_o,
  // writeback commit port
  input  logic                      commit_valid_i,
  input  logic [ID_WIDTH-1:0]       commit_id_i,
  // control / status
  input  logic                      flush_i,
`ifdef LONG_INST_SB_ERR_EN
  output logic                      err_o,
  output logic [ID_WIDTH-1:0]       err_id_o,
`endif
  output logic [ID_WIDTH:0]         pending_cnt_o
);

  sb_entry_t [NUM_ENTRIES-1:0] entries_q;
  sb_entry_t [NUM_ENTRIES-1:0] entries_d;
  logic      [NUM_ENTRIES-1:0] valid_vec;
  logic                        alloc_fire;
  logic                        raw_hit;
  logic                        waw_hit;
  logic      [ID_WIDTH:0]      cnt;

  // Flatten the registered valid bits for the encoder and counters.
  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_valid_vec
    assign valid_vec[g] = entries_q[g].valid;
  end

  // Allocation only looks at registered state, so a slot freed by this
  // cycle's commit becomes grantable one cycle later.
  sb_prio_enc #(
    .N   (NUM_ENTRIES),
    .IDW (ID_WIDTH)
  ) u_prio_enc (
    .busy_i     (valid_vec),
    .idx_o      (alloc_id_o),
    .any_free_o (alloc_ready_o)
  );

  assign alloc_fire = alloc_req_i & alloc_ready_o;

  // Hazard match: an entry being committed this cycle is bypassed by the
  // write-first register file, and x0 never creates a dependency.
  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (entries_q[i].valid &&
          !(commit_valid_i && (commit_id_i == inst_id_t'(i))) &&
          (entries_q[i].rd != '0)) begin
        if ((dec_rs1_re_i && (dec_rs1_i == entries_q[i].rd)) ||
            (dec_rs2_re_i && (dec_rs2_i == entries_q[i].rd)))
          raw_hit = 1'b1;
        if (dec_we_i && (dec_rd_i == entries_q[i].rd))
          waw_hit = 1'b1;
      end
    end
  end

  assign raw_hazard_o = raw_hit;
  assign waw_hazard_o = waw_hit;
  assign stall_o      = raw_hit | waw_hit | (alloc_req_i & ~alloc_ready_o);

  // Next-state: flush wins; otherwise commit and allocation never collide
  // because allocation only picks an entry that is currently free.
  always_comb begin
    entries_d = entries_q;
    if (flush_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_d[i].valid = 1'b0;
    end else begin
      if (commit_valid_i) entries_d[commit_id_i].valid = 1'b0;
      if (alloc_fire) begin
        entries_d[alloc_id_o].valid = 1'b1;
        entries_d[alloc_id_o].rd    = alloc_rd_i;
      end
    end
  end

  // Entry state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) entries_q <= '0;
    else     entries_q <= entries_d;
  end

  // Popcount of registered valid bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) cnt = cnt + (ID_WIDTH+1)'(valid_vec[i]);
  end

  assign pending_cnt_o = cnt;

`ifdef LONG_INST_SB_ERR_EN
  logic                err_q;
  logic [ID_WIDTH-1:0] err_id_q;
  logic                bad_commit;

  assign bad_commit = commit_valid_i & ~flush_i & ~valid_vec[commit_id_i];

  // Sticky error flag; the ID of the first offending commit is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else if (bad_commit && !err_q) begin
      err_q    <= 1'b1;
      err_id_q <= commit_id_i;
    end
  end

  assign err_o    = err_q;
  assign err_id_o = err_id_q;
`endif

endmodule : long_inst_scoreboard
`default_nettype wire

// File: tb/tb_long_inst_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : tb_long_inst_scoreboard
// Brief   : Self-checking bench for long_inst_scoreboard: directed scenarios
//           plus randomized traffic against a behavioural slot model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_long_inst_scoreboard;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int RW  = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           alloc_req_i;
  logic [RW-1:0]  alloc_rd_i;
  logic           alloc_ready_o;
  logic [IDW-1:0] alloc_id_o;
  logic [RW-1:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
  logic           dec_rs1_re_i, dec_rs2_re_i, dec_we_i;
  logic           raw_hazard_o, waw_hazard_o, stall_o;
  logic           commit_valid_i;
  logic [IDW-1:0] commit_id_i;
  logic           flush_i;
  logic [IDW:0]   pending_cnt_o;
`ifdef LONG_INST_SB_ERR_EN
  logic           err_o;
  logic [IDW-1:0] err_id_o;
`endif

  long_inst_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req_i    (alloc_req_i),
    .alloc_rd_i     (alloc_rd_i),
    .alloc_ready_o  (alloc_ready_o),
    .alloc_id_o     (alloc_id_o),
    .dec_rs1_i      (dec_rs1_i),
    .dec_rs1_re_i   (dec_rs1_re_i),
    .dec_rs2_i      (dec_rs2_i),
    .dec_rs2_re_i   (dec_rs2_re_i),
    .dec_rd_i       (dec_rd_i),
    .dec_we_i       (dec_we_i),
    .raw_hazard_o   (raw_hazard_o),
    .waw_hazard_o   (waw_hazard_o),
    .stall_o        (stall_o),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .flush_i        (flush_i),
`ifdef LONG_INST_SB_ERR_EN
    .err_o          (err_o),
    .err_id_o       (err_id_o),
`endif
    .pending_cnt_o  (pending_cnt_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a set of busy slots, each remembering its destination.
  bit            m_busy[N];
  int            m_rd[N];
  bit            m_err;
  int            m_err_id;

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_rd[i] = 0; end
    m_err = 0; m_err_id = 0;
  endfunction

  function automatic int exp_first_free();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int exp_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  // A slot blocks decode if it is busy, not retiring right now, and not x0.
  function automatic bit slot_blocks(int i);
    return m_busy[i] && m_rd[i] != 0 &&
           !(commit_valid_i && int'(commit_id_i) == i);
  endfunction

  function automatic bit exp_raw();
    for (int i = 0; i < N; i++)
      if (slot_blocks(i) && ((dec_rs1_re_i && int'(dec_rs1_i) == m_rd[i]) ||
                             (dec_rs2_re_i && int'(dec_rs2_i) == m_rd[i])))
        return 1;
    return 0;
  endfunction

  function automatic bit exp_waw();
    for (int i = 0; i < N; i++)
      if (slot_blocks(i) && dec_we_i && int'(dec_rd_i) == m_rd[i]) return 1;
    return 0;
  endfunction

  // Advance one clock, applying the scoreboard rules to the model.
  task automatic tick();
    bit nb[N];
    int nr[N];
    int ff;
    for (int i = 0; i < N; i++) begin nb[i] = m_busy[i]; nr[i] = m_rd[i]; end
    ff = exp_first_free();
    if (flush_i) begin
      for (int i = 0; i < N; i++) nb[i] = 0;
    end else begin
      if (commit_valid_i) begin
        if (!m_busy[commit_id_i] && !m_err) begin m_err = 1; m_err_id = int'(commit_id_i); end
        nb[commit_id_i] = 0;
      end
      if (alloc_req_i && ff >= 0) begin nb[ff] = 1; nr[ff] = int'(alloc_rd_i); end
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin m_busy[i] = nb[i]; m_rd[i] = nr[i]; end
  endtask

  task automatic idle_inputs();
    alloc_req_i = 0; alloc_rd_i = '0;
    dec_rs1_i = '0; dec_rs2_i = '0; dec_rd_i = '0;
    dec_rs1_re_i = 0; dec_rs2_re_i = 0; dec_we_i = 0;
    commit_valid_i = 0; commit_id_i = '0; flush_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_clear();
    #1;
    n_tests++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", alloc_ready_o); end
    n_tests++; if (alloc_id_o !== 2'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", alloc_id_o); end
    n_tests++; if (pending_cnt_o !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", pending_cnt_o); end
    n_tests++; if ({raw_hazard_o, waw_hazard_o, stall_o} !== 3'b000) begin n_fail++;
      $display("FAIL reset_hazards got=%b exp=000", {raw_hazard_o, waw_hazard_o, stall_o}); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      alloc_req_i = 1; alloc_rd_i = RW'(5 + k);
      #1;
      n_tests++; if (alloc_id_o !== IDW'(k)) begin n_fail++; $display("FAIL fill_id%0d got=%0d exp=%0d", k, alloc_id_o, k); end
      tick();
    end
    alloc_req_i = 0; #1;
    n_tests++; if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", alloc_ready_o); end
    n_tests++; if (pending_cnt_o !== 3'd4) begin n_fail++; $display("FAIL full_cnt got=%0d exp=4", pending_cnt_o); end
    alloc_req_i = 1; alloc_rd_i = 5'd20; #1;
    n_tests++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL full_stall got=%b exp=1", stall_o); end
    tick();
    alloc_req_i = 0; #1;
    n_tests++; if (pending_cnt_o !== 3'd4) begin n_fail++; $display("FAIL full_ignore_cnt got=%0d exp=4", pending_cnt_o); end
  endtask

  task automatic test_raw_bypass();
    dec_rs2_i = 5'd6; dec_rs2_re_i = 1; #1;
    n_tests++; if (raw_hazard_o !== 1'b1) begin n_fail++; $display("FAIL raw_hit got=%b exp=1", raw_hazard_o); end
    dec_rd_i = 5'd8; dec_we_i = 1; #1;
    n_tests++; if (waw_hazard_o !== 1'b1) begin n_fail++; $display("FAIL waw_hit got=%b exp=1", waw_hazard_o); end
    dec_we_i = 0;
    commit_valid_i = 1; commit_id_i = 2'd1; #1;
    n_tests++; if (raw_hazard_o !== 1'b0) begin n_fail++; $display("FAIL raw_bypass got=%b exp=0", raw_hazard_o); end
    tick();
    idle_inputs(); #1;
    n_tests++; if (alloc_ready_o !== 1'b1 || alloc_id_o !== 2'd1) begin n_fail++;
      $display("FAIL freed_id1 got ready=%b id=%0d exp ready=1 id=1", alloc_ready_o, alloc_id_o); end
    n_tests++; if (pending_cnt_o !== 3'd3) begin n_fail++; $display("FAIL freed_cnt got=%0d exp=3", pending_cnt_o); end
    alloc_req_i = 1; alloc_rd_i = 5'd6; tick(); alloc_req_i = 0;
  endtask

  task automatic test_commit_alloc_same_cycle();
    commit_valid_i = 1; commit_id_i = 2'd2; alloc_req_i = 1; alloc_rd_i = 5'd9; #1;
    n_tests++; if (alloc_ready_o !== 1'b0 || stall_o !== 1'b1) begin n_fail++;
      $display("FAIL same_cycle_grant got ready=%b stall=%b exp ready=0 stall=1", alloc_ready_o, stall_o); end
    tick();
    idle_inputs(); #1;
    n_tests++; if (alloc_id_o !== 2'd2 || alloc_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL next_cycle_id got id=%0d ready=%b exp id=2 ready=1", alloc_id_o, alloc_ready_o); end
  endtask

  task automatic test_rd_zero();
    alloc_req_i = 1; alloc_rd_i = 5'd0; #1;
    n_tests++; if (alloc_id_o !== 2'd2) begin n_fail++; $display("FAIL rd0_id got=%0d exp=2", alloc_id_o); end
    tick();
    idle_inputs();
    dec_rs1_i = 5'd0; dec_rs1_re_i = 1; dec_rd_i = 5'd0; dec_we_i = 1; #1;
    n_tests++; if (raw_hazard_o !== 1'b0 || waw_hazard_o !== 1'b0) begin n_fail++;
      $display("FAIL rd0_hazard got raw=%b waw=%b exp 0 0", raw_hazard_o, waw_hazard_o); end
    n_tests++; if (pending_cnt_o !== 3'd4) begin n_fail++; $display("FAIL rd0_cnt_alloc got=%0d exp=4", pending_cnt_o); end
    idle_inputs(); commit_valid_i = 1; commit_id_i = 2'd2; tick(); idle_inputs(); #1;
    n_tests++; if (pending_cnt_o !== 3'd3) begin n_fail++; $display("FAIL rd0_cnt_commit got=%0d exp=3", pending_cnt_o); end
  endtask

  task automatic test_flush();
    commit_valid_i = 1; commit_id_i = 2'd3; tick(); idle_inputs(); #1;
    n_tests++; if (pending_cnt_o !== 3'd2) begin n_fail++; $display("FAIL pre_flush_cnt got=%0d exp=2", pending_cnt_o); end
    flush_i = 1; alloc_req_i = 1; alloc_rd_i = 5'd11; tick(); idle_inputs(); #1;
    n_tests++; if (pending_cnt_o !== 3'd0) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=0", pending_cnt_o); end
    commit_valid_i = 1; commit_id_i = 2'd0; tick(); idle_inputs(); #1;
    n_tests++; if (pending_cnt_o !== 3'd0 || alloc_id_o !== 2'd0 || alloc_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL stale_commit got cnt=%0d id=%0d ready=%b exp 0 0 1", pending_cnt_o, alloc_id_o, alloc_ready_o); end
`ifdef LONG_INST_SB_ERR_EN
    n_tests++; if (err_o !== 1'b1 || err_id_o !== 2'd0) begin n_fail++;
      $display("FAIL stale_err got err=%b id=%0d exp err=1 id=0", err_o, err_id_o); end
`endif
  endtask

  task automatic test_random();
    int ff;
    for (int cyc = 0; cyc < 400; cyc++) begin
      alloc_req_i    = ($urandom_range(0, 1) == 1);
      alloc_rd_i     = RW'($urandom_range(0, 7));
      commit_valid_i = ($urandom_range(0, 2) != 0);
      commit_id_i    = IDW'($urandom_range(0, 3));
      flush_i        = ($urandom_range(0, 19) == 0);
      dec_rs1_i = RW'($urandom_range(0, 7)); dec_rs1_re_i = ($urandom_range(0, 1) == 1);
      dec_rs2_i = RW'($urandom_range(0, 7)); dec_rs2_re_i = ($urandom_range(0, 1) == 1);
      dec_rd_i  = RW'($urandom_range(0, 7)); dec_we_i     = ($urandom_range(0, 1) == 1);
      #1;
      ff = exp_first_free();
      n_tests++; if (alloc_ready_o !== (ff >= 0)) begin n_fail++;
        $display("FAIL rnd_ready c%0d got=%b exp=%b", cyc, alloc_ready_o, (ff >= 0)); end
      if (ff >= 0) begin
        n_tests++; if (int'(alloc_id_o) != ff) begin n_fail++;
          $display("FAIL rnd_id c%0d got=%0d exp=%0d", cyc, alloc_id_o, ff); end
      end
      n_tests++; if (int'(pending_cnt_o) != exp_count()) begin n_fail++;
        $display("FAIL rnd_cnt c%0d got=%0d exp=%0d", cyc, pending_cnt_o, exp_count()); end
      n_tests++; if (raw_hazard_o !== exp_raw() || waw_hazard_o !== exp_waw()) begin n_fail++;
        $display("FAIL rnd_hazard c%0d got raw=%b waw=%b exp raw=%b waw=%b", cyc, raw_hazard_o, waw_hazard_o, exp_raw(), exp_waw()); end
      n_tests++; if (stall_o !== (exp_raw() | exp_waw() | (alloc_req_i & (ff < 0)))) begin n_fail++;
        $display("FAIL rnd_stall c%0d got=%b", cyc, stall_o); end
`ifdef LONG_INST_SB_ERR_EN
      n_tests++; if (err_o !== m_err || (m_err && int'(err_id_o) != m_err_id)) begin n_fail++;
        $display("FAIL rnd_err c%0d got err=%b id=%0d exp err=%b id=%0d", cyc, err_o, err_id_o, m_err, m_err_id); end
`endif
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin alloc_req_i = 1; alloc_rd_i = RW'(k + 1); tick(); end
    idle_inputs(); #1;
    n_tests++; if (pending_cnt_o == 3'd0) begin n_fail++; $display("FAIL areset_setup got cnt=0 exp nonzero"); end
    #2 rst = 1; #1;
    n_tests++; if (pending_cnt_o !== 3'd0 || alloc_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL areset_immediate got cnt=%0d ready=%b exp 0 1", pending_cnt_o, alloc_ready_o); end
    @(posedge clk); #1 rst = 0; model_clear(); #1;
    n_tests++; if (pending_cnt_o !== 3'd0 || alloc_id_o !== 2'd0) begin n_fail++;
      $display("FAIL areset_release got cnt=%0d id=%0d exp 0 0", pending_cnt_o, alloc_id_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_raw_bypass();
    test_commit_alloc_same_cycle();
    test_rd_zero();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_long_inst_scoreboard
`default_nettype wire
